// File: rtl/adc_rx.sv
// Purpose: drives an 8-bit parallel ADC (power-down, sample clock) and captures its samples.
// Latency: dout/dout_vld appear on the cycle after the adc_clk falling-edge capture.
// Backpressure: none; every RUN-state capture is strobed out and cannot be stalled.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   en                1 = acquire, 0 = power the converter down
//   fmt               output format: 0 = offset binary, 1 = two's complement
//   adc_data          converter output (offset binary)
//   adc_clk, adc_pd   converter sample clock (registered) and power-down (1 = asleep)
//   dout, dout_vld    captured sample and its one-cycle strobe
//   clip              sample was at full scale (valid only with dout_vld)
//   ready             1 while samples are being delivered (RUN)
module adc_rx #(
    parameter int CLK_DIV  = 5,
    parameter int WAKE_CYC = 100,
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fmt,
    input  logic [7:0] adc_data,
    output logic       adc_clk,
    output logic       adc_pd,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       clip,
    output logic       ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAKE = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [7:0]  DIV_MAX  = 8'(CLK_DIV - 1);
    localparam logic [15:0] WAKE_MAX = 16'(WAKE_CYC - 1);
    // Only used when PIPE_LAT > 0; the FILL state is skipped otherwise.
    localparam logic [3:0]  FILL_MAX = 4'(PIPE_LAT - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        adc_clk_q, adc_clk_d;
    logic [15:0] wake_cnt_q, wake_cnt_d;
    logic [3:0]  fill_cnt_q, fill_cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_vld_q, dout_vld_d;
    logic        clip_q, clip_d;

    logic div_wrap;
    logic cap_edge;

    assign div_wrap = (div_cnt_q == DIV_MAX);
    // The edge on which the registered adc_clk falls 1->0 is the capture edge.
    assign cap_edge = (state_q != IDLE) && div_wrap && adc_clk_q;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            adc_clk_q  <= 1'b0;
            wake_cnt_q <= '0;
            fill_cnt_q <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            adc_clk_q  <= adc_clk_d;
            wake_cnt_q <= wake_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            clip_q     <= clip_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAKE;
                WAKE: begin
                    if (wake_cnt_q == WAKE_MAX) begin
                        state_d = (PIPE_LAT == 0) ? RUN : FILL;
                    end
                end
                FILL: begin
                    if (cap_edge && (fill_cnt_q == FILL_MAX)) begin
                        state_d = RUN;
                    end
                end
                RUN:  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Divider, counters and sample capture
    always_comb begin
        div_cnt_d  = div_cnt_q;
        adc_clk_d  = adc_clk_q;
        wake_cnt_d = wake_cnt_q;
        fill_cnt_d = fill_cnt_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        clip_d     = 1'b0;

        if (!en || (state_q == IDLE)) begin
            // Parked: divider and counters start from zero on the next WAKE.
            div_cnt_d  = '0;
            adc_clk_d  = 1'b0;
            wake_cnt_d = '0;
            fill_cnt_d = '0;
        end else begin
            // The divider free-runs through WAKE, FILL and RUN without a restart.
            if (div_wrap) begin
                div_cnt_d = '0;
                adc_clk_d = ~adc_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end

            if (state_q == WAKE) begin
                wake_cnt_d = wake_cnt_q + 16'd1;
            end

            // Captures in FILL flush the converter pipeline and are discarded.
            if ((state_q == FILL) && cap_edge) begin
                fill_cnt_d = fill_cnt_q + 4'd1;
            end

            if ((state_q == RUN) && cap_edge) begin
                dout_vld_d = 1'b1;
                dout_d     = adc_data ^ {fmt, 7'b0};
                clip_d     = (adc_data == 8'h00) || (adc_data == 8'hFF);
            end
        end
    end

    // Outputs
    always_comb begin
        adc_pd = (state_q == IDLE);
        ready  = (state_q == RUN);
    end

    assign adc_clk  = adc_clk_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign clip     = clip_q;

endmodule

// File: tb/tb_adc_rx.sv
// Bench for adc_rx: CLK_DIV=2, WAKE_CYC=8, PIPE_LAT=3 on the main instance and a
// PIPE_LAT=0 instance for the no-fill path. Expected samples are queued when the
// input vector is applied; a negedge monitor pops and compares on each dout_vld.
module tb_adc_rx;

    logic       clk = 1'b0;
    logic       rst, en, fmt;
    logic [7:0] adc_data;
    logic       adc_clk, adc_pd, dout_vld, clip, ready;
    logic [7:0] dout;

    logic       rst_z, en_z, fmt_z;
    logic [7:0] adc_data_z;
    logic       adc_clk_z, adc_pd_z, dout_vld_z, clip_z, ready_z;
    logic [7:0] dout_z;

    always #5 clk = ~clk;

    adc_rx #(.CLK_DIV(2), .WAKE_CYC(8), .PIPE_LAT(3)) dut (
        .clk(clk), .rst(rst), .en(en), .fmt(fmt), .adc_data(adc_data),
        .adc_clk(adc_clk), .adc_pd(adc_pd), .dout(dout), .dout_vld(dout_vld),
        .clip(clip), .ready(ready)
    );

    adc_rx #(.CLK_DIV(2), .WAKE_CYC(8), .PIPE_LAT(0)) dut_z (
        .clk(clk), .rst(rst_z), .en(en_z), .fmt(fmt_z), .adc_data(adc_data_z),
        .adc_clk(adc_clk_z), .adc_pd(adc_pd_z), .dout(dout_z), .dout_vld(dout_vld_z),
        .clip(clip_z), .ready(ready_z)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Directed vectors with hand-computed results.
    typedef struct packed {
        logic [7:0] d;
        logic       c;
    } exp_t;

    logic [7:0] vec_data [6] = '{8'h00, 8'h7F, 8'hFF, 8'h80, 8'hFF, 8'h01};
    logic       vec_fmt  [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [7:0] vec_dout [6] = '{8'h80, 8'h7F, 8'h7F, 8'h00, 8'hFF, 8'h81};
    logic       vec_clip [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] last_exp_dout = 8'h00;
    int         vec_idx = 0;
    logic       feed_pending = 1'b0;
    int         k = 0;

    // Monitor: compares every strobed sample against the scoreboard.
    always @(negedge clk) begin
        if (dout_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_vld", 32'(dout_vld), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("dout", 32'(dout), 32'(mon_e.d));
                check("clip", 32'(clip), 32'(mon_e.c));
                last_exp_dout = mon_e.d;
            end
        end else begin
            check("clip_without_vld", 32'(clip), 32'd0);
        end
    end

    // Apply the next vector and queue its expected result.
    task automatic feed();
        exp_t e;
        if (vec_idx < 6) begin
            adc_data = vec_data[vec_idx];
            fmt      = vec_fmt[vec_idx];
            e.d      = vec_dout[vec_idx];
            e.c      = vec_clip[vec_idx];
            vec_idx++;
        end else begin
            adc_data = 8'h55;
            fmt      = 1'b0;
            e.d      = 8'h55;
            e.c      = 1'b0;
        end
        sb_q.push_back(e);
    endtask

    // One clk cycle; outputs are observed 1 time unit after the rising edge. A new
    // vector goes in the cycle after a strobe, well before the next capture edge.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (feed_pending) feed();
        feed_pending = dout_vld;
    endtask

    // Called right after the edge that entered WAKE (k = 0 there).
    task automatic wake_seq(input string tag);
        int   first_rdy = -1;
        int   first_vld = -1;
        int   last_vld  = 0;
        int   falls     = 0;
        logic prev_clk  = 1'b0;
        logic [7:0] clk_pat = 8'b0110_0110;  // adc_clk after edges 1..8 (bit 0 = edge 1)
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (k <= 8) check({tag, "_adc_clk"}, 32'(adc_clk), 32'(clk_pat[k-1]));
            if (first_rdy < 0 && ready === 1'b1) first_rdy = k;
            if (dout_vld === 1'b1) begin
                if (first_vld < 0) first_vld = k;
                else check({tag, "_vld_spacing"}, k - last_vld, 4);
                last_vld = k;
            end
            if (first_vld < 0 && k > 8 && prev_clk && !adc_clk) falls++;
            prev_clk = adc_clk;
        end
        check({tag, "_ready_cycle"}, first_rdy, 20);
        check({tag, "_first_vld_cycle"}, first_vld, 24);
        check({tag, "_discarded_captures"}, falls, 3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_adc_pd"},   32'(adc_pd),   32'd1);
        check({tag, "_adc_clk"},  32'(adc_clk),  32'd0);
        check({tag, "_dout"},     32'(dout),     32'h00);
        check({tag, "_dout_vld"}, 32'(dout_vld), 32'd0);
        check({tag, "_clip"},     32'(clip),     32'd0);
        check({tag, "_ready"},    32'(ready),    32'd0);
    endtask

    initial begin
        int first_vld_z;
        int first_rdy_z;

        rst = 1'b1; en = 1'b1; fmt = 1'b0; adc_data = 8'h00;
        rst_z = 1'b1; en_z = 1'b0; fmt_z = 1'b1; adc_data_z = 8'hFF;
        feed();  // first RUN sample is loaded up front

        // Reset held with en=1.
        repeat (3) begin
            step();
            check_reset_vals("reset");
        end

        // Wake/fill from reset.
        rst = 1'b0;
        check("pd_before_wake", 32'(adc_pd), 32'd1);
        step();
        check("pd_fall", 32'(adc_pd), 32'd0);
        wake_seq("acq1");

        // en low for one cycle between strobes.
        step();
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        check("en_drop_adc_pd",   32'(adc_pd),   32'd1);
        check("en_drop_adc_clk",  32'(adc_clk),  32'd0);
        check("en_drop_ready",    32'(ready),    32'd0);
        check("en_drop_dout_vld", 32'(dout_vld), 32'd0);
        check("en_drop_dout",     32'(dout),     32'(last_exp_dout));
        step();
        check("rewake_pd", 32'(adc_pd), 32'd0);
        check("rewake_dout_hold", 32'(dout), 32'(last_exp_dout));
        wake_seq("acq2");

        // Reset pulse between strobes.
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("mid_rst");
        step();
        check("post_rst_pd", 32'(adc_pd), 32'd0);
        wake_seq("acq3");

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        // PIPE_LAT=0 instance: first capture after WAKE is strobed.
        feed_pending = 1'b0;
        en = 1'b0;
        rst_z = 1'b0;
        en_z = 1'b1;
        first_vld_z = -1;
        first_rdy_z = -1;
        step();  // dut_z enters WAKE on this edge
        for (int j = 1; j <= 20; j++) begin
            step();
            if (first_rdy_z < 0 && ready_z === 1'b1) first_rdy_z = j;
            if (first_vld_z < 0 && dout_vld_z === 1'b1) begin
                first_vld_z = j;
                check("z_dout", 32'(dout_z), 32'h7F);
                check("z_clip", 32'(clip_z), 32'd1);
            end
        end
        check("z_ready_cycle", first_rdy_z, 8);
        check("z_first_vld_cycle", first_vld_z, 12);
        check("main_idle_pd", 32'(adc_pd), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
